mem_access_ctrl: RTL and testbench

//  Load/store access controller between the datapath (ALU address, rt store data) and the word-wide

---
 rtl/mem_access_ctrl.sv | 170 +++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// ----------------------------------------------------------------------------
// mem_access_ctrl
//   Load/store access controller between the datapath and a word-wide data
//   memory. Byte addresses are converted to word indices. Loads of byte, half
//   and word are extracted from the addressed lane(s) and sign or zero
//   extended. Word stores write directly. Byte/half stores use a two-cycle
//   read-modify-write and stall the core for one cycle. Misaligned or
//   out-of-range accesses have their writes suppressed and their load data
//   forced to zero. The first such access is recorded in a sticky fault flag
//   together with its byte address.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   req_addr    byte address from the ALU
//   req_wdata   store data (sub-word data taken from the LSBs)
//   req_we      store request
//   req_re      load request
//   req_size    00 byte, 01 half, 10/11 word
//   req_uns     1 = zero-extend sub-word loads, 0 = sign-extend
//   mem_addr    word index presented to memory
//   mem_wd      memory write data
//   mem_we      memory write enable
//   mem_rd      memory read data (combinational from mem_addr)
//   rdata       extended load data
//   stall       hold PC/pipeline; requester keeps req_* stable while high
//   fault       sticky access fault
//   fault_addr  byte address of the first faulting access
// ----------------------------------------------------------------------------
module mem_access_ctrl #(
  parameter int DEPTH = 100,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  input  logic          req_we,
  input  logic          req_re,
  input  logic [1:0]    req_size,
  input  logic          req_uns,
  output logic [31:0]   mem_addr,
  output logic [31:0]   mem_wd,
  output logic          mem_we,
  input  logic [31:0]   mem_rd,
  output logic [31:0]   rdata,
  output logic          stall,
  output logic          fault,
  output logic [AW-1:0] fault_addr
);

  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } state_t;

  localparam logic [AW-3:0] DEPTH_W = (AW-2)'(DEPTH);

  state_t        state;
  state_t        state_nx;
  logic [31:0]   merge_q;
  logic [AW-3:0] idx_q;

  logic [AW-3:0] word_idx;
  logic [1:0]    lane;
  logic          is_byte;
  logic          is_half;
  logic          is_word;
  logic          bad;
  logic          do_store;
  logic          do_load;
  logic          in_rmw;
  logic          rmw_start;
  logic          fault_set;
  logic [31:0]   merged;
  logic [31:0]   load_ext;
  logic [31:0]   byte_sh;
  logic [31:0]   half_sh;

  assign word_idx = req_addr[AW-1:2];
  assign lane     = req_addr[1:0];
  assign is_byte  = (req_size == 2'b00);
  assign is_half  = (req_size == 2'b01);
  assign is_word  = req_size[1];
  assign bad      = (is_half && lane[0]) || (is_word && (lane != 2'b00)) ||
                    (word_idx >= DEPTH_W);
  // A simultaneous store and load request behaves as a store.
  assign do_store = req_we;
  assign do_load  = req_re && !req_we;
  // Reset abandons a pending write-back, so the RMW outputs are masked by rst.
  assign in_rmw   = (state == RMW_WR) && !rst;

  // Lane extraction: shift the addressed lane down to bit 0.
  assign byte_sh = mem_rd >> {lane, 3'b000};
  assign half_sh = mem_rd >> {lane[1], 4'b0000};

  always_comb begin
    unique case (req_size)
      2'b00:   load_ext = req_uns ? {24'h0, byte_sh[7:0]}
                                  : {{24{byte_sh[7]}}, byte_sh[7:0]};
      2'b01:   load_ext = req_uns ? {16'h0, half_sh[15:0]}
                                  : {{16{half_sh[15]}}, half_sh[15:0]};
      default: load_ext = mem_rd;
    endcase
  end

  // Merge the new lane(s) into the word currently held in memory.
  always_comb begin
    merged = mem_rd;
    if (is_byte) begin
      merged[{lane, 3'b000} +: 8] = req_wdata[7:0];
    end else if (is_half) begin
      merged[{lane[1], 4'b0000} +: 16] = req_wdata[15:0];
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nx  = IDLE;
    mem_addr  = 32'(word_idx);
    mem_wd    = req_wdata;
    mem_we    = 1'b0;
    rdata     = 32'h0;
    stall     = 1'b0;
    rmw_start = 1'b0;
    fault_set = 1'b0;

    if (in_rmw) begin
      mem_addr = 32'(idx_q);
      mem_wd   = merge_q;
      mem_we   = 1'b1;
    end else if ((do_store || do_load) && bad) begin
      fault_set = !fault;
    end else if (do_store) begin
      if (is_word) begin
        mem_we = 1'b1;
      end else begin
        stall     = 1'b1;
        rmw_start = 1'b1;
        state_nx  = RMW_WR;
      end
    end else if (do_load) begin
      rdata = load_ext;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      merge_q    <= 32'h0;
      idx_q      <= '0;
      fault      <= 1'b0;
      fault_addr <= '0;
    end else begin
      state <= state_nx;
      if (rmw_start) begin
        merge_q <= merged;
        idx_q   <= word_idx;
      end
      if (fault_set) begin
        fault      <= 1'b1;
        fault_addr <= req_addr;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mem_access_ctrl
//   Directed and randomized bench for mem_access_ctrl. Provides a behavioural
//   data memory and an operation-level reference model (byte arrays, sticky
//   fault) from which every expected value is computed.
// ----------------------------------------------------------------------------
module tb_mem_access_ctrl;

  localparam int DEPTH = 100;
  localparam int AW    = 32;

  logic          clk;
  logic          rst;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          req_we;
  logic          req_re;
  logic [1:0]    req_size;
  logic          req_uns;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wd;
  logic          mem_we;
  logic [31:0]   mem_rd;
  logic [31:0]   rdata;
  logic          stall;
  logic          fault;
  logic [AW-1:0] fault_addr;

  mem_access_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_we     (req_we),
    .req_re     (req_re),
    .req_size   (req_size),
    .req_uns    (req_uns),
    .mem_addr   (mem_addr),
    .mem_wd     (mem_wd),
    .mem_we     (mem_we),
    .mem_rd     (mem_rd),
    .rdata      (rdata),
    .stall      (stall),
    .fault      (fault),
    .fault_addr (fault_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural data memory driven by the DUT.
  logic [31:0] mem [DEPTH];
  always_comb mem_rd = (mem_addr < 32'(DEPTH)) ? mem[mem_addr[6:0]] : 32'h0;
  always @(posedge clk) begin
    if (mem_we && (mem_addr < 32'(DEPTH))) mem[mem_addr[6:0]] <= mem_wd;
  end

  // Reference model state.
  logic [31:0] ref_mem [DEPTH];
  logic        ref_fault;
  logic [31:0] ref_fault_addr;

  int tests;
  int fails;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int size_bytes(input logic [1:0] sz);
    if (sz == 2'd0) return 1;
    if (sz == 2'd1) return 2;
    return 4;
  endfunction

  function automatic bit ref_bad(input logic [31:0] a, input logic [1:0] sz);
    if ((a / 4) >= DEPTH) return 1'b1;
    if (sz == 2'd1 && (a % 2) != 0) return 1'b1;
    if (sz >= 2'd2 && (a % 4) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [31:0] a,
                                            input logic [31:0] d, input logic [1:0] sz);
    logic [7:0] b [4];
    int n, base;
    for (int i = 0; i < 4; i++) b[i] = 8'(old >> (8 * i));
    n    = size_bytes(sz);
    base = (n == 4) ? 0 : int'(a % 4);
    for (int k = 0; k < n; k++) b[base + k] = 8'(d >> (8 * k));
    return {b[3], b[2], b[1], b[0]};
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [31:0] a,
                                           input logic [1:0] sz, input bit uns);
    logic [31:0] v;
    int n, base;
    n    = size_bytes(sz);
    base = (n == 4) ? 0 : int'(a % 4);
    v    = 32'h0;
    for (int k = 0; k < n; k++) v = v | (((w >> (8 * (base + k))) & 32'hFF) << (8 * k));
    if (!uns && n < 4 && (((v >> (8 * n - 1)) & 32'd1) == 32'd1))
      v = v | ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  task automatic drive_idle();
    req_addr  = '0;
    req_wdata = '0;
    req_we    = 1'b0;
    req_re    = 1'b0;
    req_size  = 2'b10;
    req_uns   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_fault", {31'h0, fault}, 32'h0);
    check("rst_fault_addr", fault_addr, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    ref_fault      = 1'b0;
    ref_fault_addr = 32'h0;
  endtask

  // One complete request; sub-word stores take two cycles.
  task automatic do_op(input string tag, input bit we, input bit re, input logic [1:0] sz,
                       input bit uns, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] idx;
    logic [31:0] exp_word;
    @(negedge clk);
    req_addr  = a;
    req_wdata = d;
    req_we    = we;
    req_re    = re;
    req_size  = sz;
    req_uns   = uns;
    idx       = a >> 2;
    #1;
    if (!(we || re)) begin
      check({tag, "_idle_we"}, {31'h0, mem_we}, 32'h0);
      check({tag, "_idle_stall"}, {31'h0, stall}, 32'h0);
      check({tag, "_idle_rdata"}, rdata, 32'h0);
    end else if (ref_bad(a, sz)) begin
      check({tag, "_bad_we"}, {31'h0, mem_we}, 32'h0);
      check({tag, "_bad_stall"}, {31'h0, stall}, 32'h0);
      check({tag, "_bad_rdata"}, rdata, 32'h0);
      if (!ref_fault) begin
        ref_fault      = 1'b1;
        ref_fault_addr = a;
      end
    end else if (we && sz >= 2'd2) begin
      check({tag, "_sw_we"}, {31'h0, mem_we}, 32'h1);
      check({tag, "_sw_wd"}, mem_wd, d);
      check({tag, "_sw_addr"}, mem_addr, idx);
      check({tag, "_sw_stall"}, {31'h0, stall}, 32'h0);
      ref_mem[idx[6:0]] = d;
    end else if (we) begin
      check({tag, "_rmw1_stall"}, {31'h0, stall}, 32'h1);
      check({tag, "_rmw1_we"}, {31'h0, mem_we}, 32'h0);
      exp_word = ref_store(ref_mem[idx[6:0]], a, d, sz);
      @(negedge clk);
      #1;
      check({tag, "_rmw2_we"}, {31'h0, mem_we}, 32'h1);
      check({tag, "_rmw2_wd"}, mem_wd, exp_word);
      check({tag, "_rmw2_addr"}, mem_addr, idx);
      check({tag, "_rmw2_stall"}, {31'h0, stall}, 32'h0);
      check({tag, "_rmw2_rdata"}, rdata, 32'h0);
      ref_mem[idx[6:0]] = exp_word;
    end else begin
      check({tag, "_ld_rdata"}, rdata, ref_load(ref_mem[idx[6:0]], a, sz, uns));
      check({tag, "_ld_stall"}, {31'h0, stall}, 32'h0);
      check({tag, "_ld_we"}, {31'h0, mem_we}, 32'h0);
    end
    @(posedge clk);
    #1;
    check({tag, "_fault"}, {31'h0, fault}, {31'h0, ref_fault});
    check({tag, "_fault_addr"}, fault_addr, ref_fault_addr);
  endtask

  initial begin
    logic [31:0] ra;
    logic [1:0]  rsz;
    int          kind;
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    drive_idle();
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = 32'h0;
      ref_mem[i] = 32'h0;
    end
    ref_fault      = 1'b0;
    ref_fault_addr = 32'h0;

    do_reset();
    do_op("idle0", 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);

    // Word store then load.
    do_op("t1_sw", 1'b1, 1'b0, 2'b10, 1'b0, 32'h8, 32'hDEADBEEF);
    do_op("t1_lw", 1'b0, 1'b1, 2'b10, 1'b0, 32'h8, 32'h0);

    // Byte store via read-modify-write, then byte loads.
    do_op("t2_sb", 1'b1, 1'b0, 2'b00, 1'b0, 32'h9, 32'h00000055);
    check("t2_mem", mem[2], 32'hDEAD55EF);
    do_op("t2_lb9", 1'b0, 1'b1, 2'b00, 1'b0, 32'h9, 32'h0);
    do_op("t2_lbB", 1'b0, 1'b1, 2'b00, 1'b0, 32'hB, 32'h0);
    do_op("t2_lbuB", 1'b0, 1'b1, 2'b00, 1'b1, 32'hB, 32'h0);

    // Halfword store, load, and back-to-back sub-word stores to one word.
    do_op("t3_sh", 1'b1, 1'b0, 2'b01, 1'b0, 32'hA, 32'h00001234);
    check("t3_mem", mem[2], 32'h123455EF);
    do_op("t3_lh", 1'b0, 1'b1, 2'b01, 1'b0, 32'hA, 32'h0);
    do_op("t3_sh2", 1'b1, 1'b0, 2'b01, 1'b0, 32'h8, 32'h0000CAFE);
    do_op("t3_sb2", 1'b1, 1'b0, 2'b00, 1'b0, 32'hB, 32'h00000077);
    check("t3_mem_b2b", mem[2], 32'h7734CAFE);
    do_op("t3_lhs", 1'b0, 1'b1, 2'b01, 1'b0, 32'h8, 32'h0);

    // Misaligned accesses; the first fault address sticks.
    do_op("t4_lh5", 1'b0, 1'b1, 2'b01, 1'b0, 32'h5, 32'h0);
    check("t4_fault_addr", fault_addr, 32'h5);
    do_op("t4_sw3", 1'b1, 1'b0, 2'b10, 1'b0, 32'h3, 32'h11111111);
    check("t4_fault_addr_kept", fault_addr, 32'h5);

    // Range boundary.
    do_op("t5_sw_oob", 1'b1, 1'b0, 2'b10, 1'b0, 32'(4 * DEPTH), 32'hA5A5A5A5);
    do_op("t5_sw_last", 1'b1, 1'b0, 2'b10, 1'b0, 32'(4 * DEPTH - 4), 32'h5A5A5A5A);
    do_op("t5_lw_last", 1'b0, 1'b1, 2'b10, 1'b0, 32'(4 * DEPTH - 4), 32'h0);
    do_op("t5_lb_oob", 1'b0, 1'b1, 2'b00, 1'b1, 32'(4 * DEPTH + 1), 32'h0);

    // Reset during the write-back cycle abandons the store.
    @(negedge clk);
    req_addr  = 32'h9;
    req_wdata = 32'h000000AA;
    req_we    = 1'b1;
    req_re    = 1'b0;
    req_size  = 2'b00;
    req_uns   = 1'b0;
    #1;
    check("t6_stall", {31'h0, stall}, 32'h1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6_rst_we", {31'h0, mem_we}, 32'h0);
    @(posedge clk);
    #1;
    check("t6_fault", {31'h0, fault}, 32'h0);
    check("t6_fault_addr", fault_addr, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive_idle();
    ref_fault      = 1'b0;
    ref_fault_addr = 32'h0;
    check("t6_mem_kept", mem[2], 32'h7734CAFE);
    do_op("t6_lw", 1'b0, 1'b1, 2'b10, 1'b0, 32'h8, 32'h0);
    do_op("t6_idle", 1'b0, 1'b0, 2'b00, 1'b0, 32'h9, 32'h0);

    // Randomized mix of loads, stores and faulting accesses.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      ra   = (32'($urandom_range(0, DEPTH + 2)) << 2) | 32'($urandom_range(0, 3));
      rsz  = 2'($urandom_range(0, 3));
      kind = int'($urandom_range(0, 3));
      do_op("rnd", kind[0], kind[1], rsz, 1'($urandom_range(0, 1)), ra, $urandom);
    end

    @(negedge clk);
    drive_idle();
    for (int i = 0; i < DEPTH; i++) check("final_mem", mem[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
